// File: rtl/vga_pkg.sv
// Shared VGA constants, colour helpers and flash state encoding.
package vga_pkg;

    localparam int          PIX_W       = 12;
    localparam logic [11:0] TRANSPARENT = 12'hCBE;
    localparam logic [11:0] BLACK       = 12'h000;
    localparam logic [11:0] RED_NIBBLE  = 12'hF00;

    // Flash FSM encoding
    localparam logic IDLE  = 1'b0;
    localparam logic FLASH = 1'b1;

    typedef enum logic {
        ST_IDLE  = IDLE,
        ST_FLASH = FLASH
    } flash_state_e;

    // Force the red nibble to full scale, leaving green and blue alone.
    function automatic logic [PIX_W-1:0] rgb_tint_red(input logic [PIX_W-1:0] pixel);
        return pixel | RED_NIBBLE;
    endfunction

endpackage

// File: rtl/vga_prio_enc.sv
// Lowest-index-first priority encoder with a found flag.
module vga_prio_enc #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    // Scan from the top so the lowest requesting index is the last write.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IDX_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_layer_mixer.sv
// Two-stage priority layer compositor with blink and hit-flash red tint.
module vga_layer_mixer #(
    parameter int               NUM_LAYERS   = 8,
    parameter int               PIX_W        = vga_pkg::PIX_W,
    parameter logic [PIX_W-1:0] TRANSPARENT  = vga_pkg::TRANSPARENT,
    parameter logic [PIX_W-1:0] BG_COLOR     = vga_pkg::BLACK,
    parameter int               BLINK_PERIOD = 16,
    parameter int               HIT_FRAMES   = 30,
    localparam int              TL_W         = $clog2(NUM_LAYERS) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pix_en,
    input  logic                        vga_valid,
    input  logic                        frame_start,
    input  logic [NUM_LAYERS*PIX_W-1:0] layer_pixels,
    input  logic [NUM_LAYERS-1:0]       layer_en,
    input  logic [NUM_LAYERS-1:0]       blink_mask,
    input  logic                        hit,
    output logic [PIX_W-1:0]            pixel,
    output logic                        pixel_valid,
    output logic [TL_W-1:0]             top_layer
);
    import vga_pkg::*;

    localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int BC_W  = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
    localparam int FC_W  = $clog2(HIT_FRAMES + 1);

    logic [NUM_LAYERS-1:0][PIX_W-1:0] lay;
    assign lay = layer_pixels;

    // ---------------- blink timer ----------------
    logic [BC_W-1:0] blink_cnt_q, blink_cnt_d;
    logic            blink_phase_q, blink_phase_d;

    // Count frames; toggle the blink phase each time the count wraps.
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_start) begin
            if (blink_cnt_q == BC_W'(BLINK_PERIOD - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // ---------------- flash FSM ----------------
    flash_state_e    state_q, state_d;
    logic [FC_W-1:0] flash_cnt_q, flash_cnt_d;

    // Hit (re)loads the frame budget; a simultaneous frame_start is ignored.
    always_comb begin
        state_d     = state_q;
        flash_cnt_d = flash_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    state_d     = ST_FLASH;
                    flash_cnt_d = FC_W'(HIT_FRAMES);
                end
            end
            ST_FLASH: begin
                if (hit) begin
                    flash_cnt_d = FC_W'(HIT_FRAMES);
                end else if (frame_start) begin
                    if (flash_cnt_q == FC_W'(1)) begin
                        state_d     = ST_IDLE;
                        flash_cnt_d = '0;
                    end else begin
                        flash_cnt_d = flash_cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                flash_cnt_d = '0;
            end
        endcase
    end

    // ---------------- S1: qualify ----------------
    logic [NUM_LAYERS-1:0] qual_d;

    // A layer qualifies when enabled, not keyed out and not blinked off.
    always_comb begin
        qual_d = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            qual_d[i] = layer_en[i] && (lay[i] != TRANSPARENT)
                        && !(blink_mask[i] && blink_phase_q);
        end
    end

    logic [NUM_LAYERS-1:0][PIX_W-1:0] s1_pix_q;
    logic [NUM_LAYERS-1:0]            s1_qual_q;
    logic [2:1]                       vld_pipe_q;

    // ---------------- S2: select, blank, tint ----------------
    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic [PIX_W-1:0] win_pix, pixel_d;
    logic [TL_W-1:0]  top_d;

    vga_prio_enc #(.N(NUM_LAYERS), .IDX_W(IDX_W)) u_prio (
        .req_i   (s1_qual_q),
        .idx_o   (win_idx),
        .found_o (win_found)
    );

    // Blanked pixels win over the flash tint.
    always_comb begin
        win_pix = win_found ? s1_pix_q[win_idx] : BG_COLOR;
        if (state_q == ST_FLASH) win_pix = rgb_tint_red(win_pix);
        pixel_d = vld_pipe_q[1] ? win_pix : '0;
        top_d   = (vld_pipe_q[1] && win_found) ? TL_W'(win_idx) : TL_W'(NUM_LAYERS);
    end

    // All state; pipeline stages advance only on pixel strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            state_q       <= ST_IDLE;
            flash_cnt_q   <= '0;
            s1_pix_q      <= '0;
            s1_qual_q     <= '0;
            vld_pipe_q    <= '0;
            pixel         <= '0;
            top_layer     <= TL_W'(NUM_LAYERS);
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            state_q       <= state_d;
            flash_cnt_q   <= flash_cnt_d;
            if (pix_en) begin
                s1_pix_q   <= lay;
                s1_qual_q  <= qual_d;
                vld_pipe_q <= {vld_pipe_q[1], vga_valid};
                pixel      <= pixel_d;
                top_layer  <= top_d;
            end
        end
    end

    assign pixel_valid = vld_pipe_q[2];

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Self-checking bench: directed scenarios plus random traffic against a frame-level model.
module tb_vga_layer_mixer;

    localparam int NL = 8;
    localparam int PW = 12;
    localparam int BP = 2;
    localparam int HF = 3;
    localparam logic [11:0] KEY = 12'hCBE;

    logic           clk = 1'b0;
    logic           rst, pix_en, vga_valid, frame_start, hit;
    logic [NL*PW-1:0] layer_pixels;
    logic [NL-1:0]  layer_en, blink_mask;
    logic [PW-1:0]  pixel;
    logic           pixel_valid;
    logic [3:0]     top_layer;

    int errors = 0;
    int checks = 0;

    vga_layer_mixer #(
        .NUM_LAYERS(NL), .PIX_W(PW), .TRANSPARENT(KEY), .BG_COLOR(12'h000),
        .BLINK_PERIOD(BP), .HIT_FRAMES(HF)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .vga_valid(vga_valid),
        .frame_start(frame_start), .layer_pixels(layer_pixels),
        .layer_en(layer_en), .blink_mask(blink_mask), .hit(hit),
        .pixel(pixel), .pixel_valid(pixel_valid), .top_layer(top_layer)
    );

    always #5 clk = ~clk;

    // Reference model: frames seen, flash frames left, one staged pixel set.
    int           m_frames, m_flash_left;
    logic [NL*PW-1:0] m_st_pix;
    logic [NL-1:0] m_st_qual;
    logic         m_st_vld;
    logic [11:0]  e_pix;
    logic         e_vld;
    logic [3:0]   e_top;

    task automatic model_edge();
        logic [11:0] p;
        int   win;
        bit   phase;
        if (rst) begin
            m_frames = 0; m_flash_left = 0;
            m_st_pix = '0; m_st_qual = '0; m_st_vld = 1'b0;
            e_pix = 12'h000; e_vld = 1'b0; e_top = 4'(NL);
        end else begin
            if (pix_en) begin
                win = NL;
                for (int i = NL - 1; i >= 0; i--) if (m_st_qual[i]) win = i;
                p = (win < NL) ? m_st_pix[win*PW +: PW] : 12'h000;
                if (m_flash_left > 0) p = {4'hF, p[7:0]};
                e_vld = m_st_vld;
                e_pix = m_st_vld ? p : 12'h000;
                e_top = m_st_vld ? 4'(win) : 4'(NL);
                phase = ((m_frames / BP) % 2) == 1;
                for (int i = 0; i < NL; i++)
                    m_st_qual[i] = layer_en[i] && (layer_pixels[i*PW +: PW] != KEY)
                                   && !(blink_mask[i] && phase);
                m_st_pix = layer_pixels;
                m_st_vld = vga_valid;
            end
            if (hit) m_flash_left = HF;
            else if (frame_start && m_flash_left > 0) m_flash_left--;
            if (frame_start) m_frames++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: model the edge, then compare all outputs 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_pixel", 32'(pixel), 32'(e_pix));
        chk("model_valid", 32'(pixel_valid), 32'(e_vld));
        chk("model_top", 32'(top_layer), 32'(e_top));
        frame_start = 1'b0;
        hit = 1'b0;
    endtask

    task automatic set_all(input logic [11:0] v);
        for (int i = 0; i < NL; i++) layer_pixels[i*PW +: PW] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pix_en = 1'b1; vga_valid = 1'b1; frame_start = 1'b0; hit = 1'b0;
        layer_en = '1; blink_mask = '0; layer_pixels = '0;
        set_all(KEY);

        // Reset state
        tick();
        chk("rst_pixel", 32'(pixel), 32'h0);
        chk("rst_valid", 32'(pixel_valid), 32'h0);
        chk("rst_top", 32'(top_layer), 32'd8);
        rst = 1'b0;

        // Priority between opaque layers 0 and 2
        layer_pixels[0*PW +: PW] = 12'h111;
        layer_pixels[2*PW +: PW] = 12'h333;
        tick(); tick();
        chk("prio_l0_pix", 32'(pixel), 32'h111);
        chk("prio_l0_top", 32'(top_layer), 32'd0);
        layer_en[0] = 1'b0;
        tick(); tick();
        chk("prio_l2_pix", 32'(pixel), 32'h333);
        chk("prio_l2_top", 32'(top_layer), 32'd2);
        layer_en = '1;

        // Nothing qualifies -> background
        set_all(KEY);
        tick(); tick();
        chk("bg_pix", 32'(pixel), 32'h000);
        chk("bg_top", 32'(top_layer), 32'd8);

        // Blanking
        layer_pixels[0*PW +: PW] = 12'h111;
        vga_valid = 1'b0;
        tick(); tick();
        chk("blank_pix", 32'(pixel), 32'h0);
        chk("blank_vld", 32'(pixel_valid), 32'h0);
        chk("blank_top", 32'(top_layer), 32'd8);
        vga_valid = 1'b1;

        // Latency and hold: strobe every 4th clock, inputs change each strobe
        for (int s = 0; s < 12; s++) begin
            for (int i = 0; i < NL; i++)
                layer_pixels[i*PW +: PW] = ($urandom % 2) ? KEY : 12'($urandom);
            layer_en  = 8'($urandom);
            vga_valid = ($urandom % 4) != 0;
            pix_en = 1'b1; tick();
            pix_en = 1'b0; tick(); tick(); tick();
        end
        pix_en = 1'b1;

        // Blink, BLINK_PERIOD=2
        do_reset();
        vga_valid = 1'b1; layer_en = '1; set_all(KEY);
        layer_pixels[0*PW +: PW] = 12'h111;
        layer_pixels[1*PW +: PW] = 12'h222;
        blink_mask = 8'b0000_0001;
        for (int f = 0; f < 6; f++) begin
            tick(); tick(); tick();
            chk($sformatf("blink_f%0d", f), 32'(pixel), ((f / 2) % 2 == 1) ? 32'h222 : 32'h111);
            frame_start = 1'b1; tick();
        end
        blink_mask = '0;

        // Flash, HIT_FRAMES=3
        do_reset();
        set_all(KEY);
        layer_pixels[0*PW +: PW] = 12'h123;
        hit = 1'b1; tick();
        for (int f = 0; f < 3; f++) begin
            tick(); tick();
            chk($sformatf("flash_f%0d", f), 32'(pixel), 32'hF23);
            frame_start = 1'b1; tick();
        end
        tick(); tick();
        chk("flash_end", 32'(pixel), 32'h123);

        // Retrigger coinciding with the 2nd frame_start
        hit = 1'b1; tick();
        tick(); frame_start = 1'b1; tick();
        tick(); frame_start = 1'b1; hit = 1'b1; tick();
        for (int f = 0; f < 3; f++) begin
            tick(); tick();
            chk($sformatf("retrig_f%0d", f), 32'(pixel), 32'hF23);
            frame_start = 1'b1; tick();
        end
        tick(); tick();
        chk("retrig_end", 32'(pixel), 32'h123);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NL; i++)
                layer_pixels[i*PW +: PW] = ($urandom % 2) ? KEY : 12'($urandom);
            layer_en    = 8'($urandom);
            blink_mask  = 8'($urandom);
            vga_valid   = ($urandom % 5) != 0;
            pix_en      = ($urandom % 3) != 0;
            frame_start = ($urandom % 6) == 0;
            hit         = ($urandom % 40) == 0;
            tick();
        end
        pix_en = 1'b1;

        // Reset mid-flash and mid-stream
        set_all(KEY);
        layer_pixels[3*PW +: PW] = 12'h456;
        layer_en = '1; blink_mask = '0; vga_valid = 1'b1;
        hit = 1'b1; tick(); tick(); tick();
        chk("pre_rst_tint", 32'(pixel), 32'hF56);
        rst = 1'b1; tick();
        chk("midrst_pix", 32'(pixel), 32'h0);
        chk("midrst_vld", 32'(pixel_valid), 32'h0);
        chk("midrst_top", 32'(top_layer), 32'd8);
        rst = 1'b0;
        tick();
        chk("post_rst_s1_vld", 32'(pixel_valid), 32'h0);
        tick();
        chk("post_rst_pix", 32'(pixel), 32'h456);
        chk("post_rst_vld", 32'(pixel_valid), 32'h1);
        chk("post_rst_top", 32'(top_layer), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_layer_mixer.md
Name: vga_layer_mixer

Overview:
- Parametrised, pipelined successor to the combinational VGA layer compositor.
- Merges NUM_LAYERS sprite/map layers by fixed priority, using a transparency key and per-layer enables.
- Adds frame-synchronous blinking of selected layers and a timed "hit flash" red tint.
- Sits between the per-object pixel generators and the {vgaRed, vgaGreen, vgaBlue} output registers.

Parameters:
- NUM_LAYERS, 8: number of input layers; index 0 has the highest priority.
- PIX_W, 12: bits per pixel, in RGB 4:4:4 packing {R,G,B}.
- TRANSPARENT, 12'hCBE: colour key meaning "no pixel here".
- BG_COLOR, 12'h000: output colour when no layer qualifies.
- BLINK_PERIOD, 16: frames per blink half-period (minimum 1).
- HIT_FRAMES, 30: frames the hit flash lasts (minimum 1).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- pix_en, input, 1: pixel strobe; the pipeline advances only when this is 1.
- vga_valid, input, 1: active-video flag, aligned with layer_pixels.
- frame_start, input, 1: one-clk pulse per frame, e.g. at vsync. Independent of pix_en.
- layer_pixels, input, NUM_LAYERS*PIX_W: flattened layer bus; layer i occupies bits [i*PIX_W +: PIX_W].
- layer_en, input, NUM_LAYERS: a layer whose bit is 0 is treated as transparent.
- blink_mask, input, NUM_LAYERS: layers that are hidden during the blink-off phase.
- hit, input, 1: one-clk pulse that starts or restarts the red flash.
- pixel, output, PIX_W: composited colour.
- pixel_valid, output, 1: vga_valid delayed to align with pixel.
- top_layer, output, $clog2(NUM_LAYERS)+1: index of the winning layer; NUM_LAYERS means background.

Behaviour:
- Reset (rst=1 at a clk edge):
  - pixel=0, pixel_valid=0, top_layer=NUM_LAYERS.
  - Pipeline registers cleared, blink counter=0, blink_phase=0 (visible).
  - Flash FSM set to IDLE with its counter at 0.
  - Reset applied mid-frame or mid-flash aborts everything immediately. No partial pixel is emitted afterwards.
- Qualification: layer i qualifies iff layer_en[i] && pixel_i != TRANSPARENT && !(blink_mask[i] && blink_phase).
- Pipeline: two stages, each updating only on clk edges with pix_en=1.
  - S1 registers the pixel bus, vga_valid and the qualify vector.
  - S2 priority-encodes the lowest qualifying index, muxes its pixel (BG_COLOR if none), applies blanking and tint, then registers pixel, pixel_valid and top_layer.
  - Latency is exactly 2 pix_en strobes. Sync signals must be delayed by the same amount by the instantiating block.
  - With pix_en=0, all outputs hold.
- Blanking: if the S1-stage vga_valid=0, then pixel=0 and top_layer=NUM_LAYERS, regardless of flash state.
- Blink timer (advances on frame_start only):
  - counter increments 0..BLINK_PERIOD-1.
  - On wrap, counter returns to 0 and blink_phase toggles.
  - blink_phase is sampled in S1, so it changes only between pixels.
- Flash FSM, states IDLE and FLASH:
  - IDLE + hit -> FLASH, flash_cnt=HIT_FRAMES.
  - FLASH + frame_start -> flash_cnt-1. When flash_cnt is 1 at that frame_start, go to IDLE with flash_cnt=0.
  - FLASH + hit -> flash_cnt reloads to HIT_FRAMES (retrigger).
  - hit and frame_start in the same cycle -> the reload wins; no decrement that cycle.
- Tint: in FLASH, every valid output pixel has its red nibble forced to 4'hF; G and B are unchanged. BG_COLOR is tinted as well.
- Widths:
  - flash_cnt is $clog2(HIT_FRAMES+1) bits.
  - The blink counter is $clog2(BLINK_PERIOD) bits, with a minimum of 1 bit.
  - No arithmetic overflow is possible.
- Ties: none are possible, since priority is strictly by index.
- Changing layer_en or blink_mask mid-line takes effect on the next pix_en strobe.

Decomposition:
- Shared package (vga_pkg) holds:
  - constants PIX_W, TRANSPARENT, BLACK, and the RED_NIBBLE mask;
  - a function rgb_tint_red(pixel);
  - the flash state encoding localparams (IDLE=0, FLASH=1).
- One natural sub-module, vga_prio_enc: a parametrised lowest-index-first priority encoder with a found flag. It is reused by the hitbox logic.
- Blink timer and flash FSM stay inline.

Test Plan:
- Layers 0 and 2 opaque (0x111, 0x333), all others 0xCBE, all enables 1, vga_valid=1, pix_en every clk -> pixel=0x111 and top_layer=0 two strobes later; with layer_en[0]=0, pixel=0x333 and top_layer=2.
- All layers 0xCBE -> pixel=BG_COLOR=0x000 and top_layer=8. Set vga_valid=0 with opaque layers -> pixel=0, pixel_valid=0, two strobes later.
- Latency and hold: pix_en on every 4th clk, changing inputs each strobe -> output follows exactly 2 strobes behind and holds between strobes.
- Blink: BLINK_PERIOD=2, layer 0=0x111 with blink_mask[0]=1, layer 1=0x222 -> output 0x111 for frames 0-1, 0x222 for frames 2-3, and 0x111 again from frame 4.
- Flash: HIT_FRAMES=3, opaque 0x123, hit pulse -> output 0xF23 for 3 frame_starts, then 0x123. A hit coinciding with the 2nd frame_start reloads -> 3 further frames of 0xF23.
- Reset mid-flash and mid-pixel stream -> next cycle pixel=0, pixel_valid=0, FSM in IDLE, blink_phase=0. After release, the first valid pixel appears 2 strobes later, untinted.
